// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: on a rising edge of sent_trig_i, reads 32-bit words from
// the transmit buffer RAM and feeds their bytes (little-endian) one at a time
// to the UART transmitter, reporting progress and completion.
//
// Optional feature: define UART_SEQ_ABORT_EN to add abort_i, which stops the
// transfer after the byte currently in flight.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN         clock, async active-low reset
//   data_length_i, sent_trig_i        byte count and start request
//   buf_rd_en_o, buf_rd_addr_o        buffer read strobe / word address
//   buf_rd_data_i                     buffer read data (cycle after strobe)
//   tx_data_o, tx_start_o, tx_done_i  UART TX byte handshake
//   busy_o, done_o, byte_cnt_o        status to the control registers
//   abort_i                           (UART_SEQ_ABORT_EN only) stop request
module uart_tx_sequencer #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_BUF_ADDR_WIDTH   = 8,
   parameter int unsigned C_LEN_WIDTH        = 10
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_LEN_WIDTH-1:0]        data_length_i,
   input  logic                          sent_trig_i,
   output logic                          buf_rd_en_o,
   output logic [C_BUF_ADDR_WIDTH-1:0]   buf_rd_addr_o,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] buf_rd_data_i,
   output logic [7:0]                    tx_data_o,
   output logic                          tx_start_o,
   input  logic                          tx_done_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [C_LEN_WIDTH-1:0]        byte_cnt_o
`ifdef UART_SEQ_ABORT_EN
   ,
   input  logic                          abort_i
`endif
);

   // Byte index spans the whole buffer so the word address wraps naturally.
   localparam int unsigned IDX_W = C_BUF_ADDR_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_RD, S_SEND, S_WAIT_TX, S_DONE
   } state_e;

   state_e                          state_q, state_d;
   logic                            trig_q;
   logic [C_LEN_WIDTH-1:0]          len_q, len_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   word_q, word_d;
   logic [C_LEN_WIDTH-1:0]          cnt_d;
   logic                            rd_en_d, tx_start_d, busy_d, done_d;
   logic [C_BUF_ADDR_WIDTH-1:0]     rd_addr_d;
   logic [7:0]                      tx_data_d;
   logic                            trig_edge;
   logic                            abort_now;

   assign trig_edge = sent_trig_i & ~trig_q;

`ifdef UART_SEQ_ABORT_EN
   // Sticky abort request; only honoured while a transfer is in progress.
   logic abort_q;
   assign abort_now = abort_q |
                      (abort_i & (state_q != S_IDLE) & (state_q != S_DONE));

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) abort_q <= 1'b0;
      else if (state_q == S_DONE) abort_q <= 1'b0;
      else abort_q <= abort_now;
   end
`else
   assign abort_now = 1'b0;
`endif

   // Next-state and next-output logic; outputs follow the next state so they
   // are valid in the cycle the FSM occupies that state.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      word_d  = word_q;
      cnt_d   = byte_cnt_o;

      case (state_q)
         S_IDLE: begin
            if (trig_edge) begin
               len_d   = data_length_i;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = (data_length_i == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH:   state_d = S_WAIT_RD;
         S_WAIT_RD: begin
            word_d  = buf_rd_data_i;
            state_d = abort_now ? S_DONE : S_SEND;
         end
         S_SEND:    state_d = S_WAIT_TX;
         S_WAIT_TX: begin
            if (tx_done_i) begin
               cnt_d = byte_cnt_o + C_LEN_WIDTH'(1);
               idx_d = idx_q + IDX_W'(1);
               if (cnt_d == len_q)        state_d = S_DONE;
               else if (abort_now)        state_d = S_DONE;
               else if (idx_d[1:0] == 2'b00) state_d = S_FETCH;
               else                       state_d = S_SEND;
            end
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      rd_en_d    = (state_d == S_FETCH);
      rd_addr_d  = rd_en_d ? idx_d[IDX_W-1:2] : buf_rd_addr_o;
      tx_start_d = (state_d == S_SEND);
      tx_data_d  = tx_start_d ? word_d[{idx_d[1:0], 3'b000} +: 8] : tx_data_o;
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q       <= S_IDLE;
         trig_q        <= 1'b0;
         len_q         <= '0;
         idx_q         <= '0;
         word_q        <= '0;
         byte_cnt_o    <= '0;
         buf_rd_en_o   <= 1'b0;
         buf_rd_addr_o <= '0;
         tx_start_o    <= 1'b0;
         tx_data_o     <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         state_q       <= state_d;
         trig_q        <= sent_trig_i;
         len_q         <= len_d;
         idx_q         <= idx_d;
         word_q        <= word_d;
         byte_cnt_o    <= cnt_d;
         buf_rd_en_o   <= rd_en_d;
         buf_rd_addr_o <= rd_addr_d;
         tx_start_o    <= tx_start_d;
         tx_data_o     <= tx_data_d;
         busy_o        <= busy_d;
         done_o        <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: randomized bench for uart_tx_sequencer. A buffer RAM
// model and a UART TX model respond to the DUT; observed bytes, read
// addresses and handshake timing are compared against expectations computed
// directly from the buffer contents and the transfer length.
module tb_uart_tx_sequencer;

   localparam int unsigned AW = 8;
   localparam int unsigned LW = 10;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst_n;
   logic [LW-1:0] data_length_i;
   logic          sent_trig_i;
   logic          buf_rd_en_o;
   logic [AW-1:0] buf_rd_addr_o;
   logic [DW-1:0] buf_rd_data_i;
   logic [7:0]    tx_data_o;
   logic          tx_start_o;
   logic          tx_done_i;
   logic          busy_o;
   logic          done_o;
   logic [LW-1:0] byte_cnt_o;
`ifdef UART_SEQ_ABORT_EN
   logic          abort_i;
`endif

   logic uart_done, inj_done, main_done;
   assign tx_done_i = uart_done | inj_done | main_done;

   uart_tx_sequencer #(
      .C_S_AXI_DATA_WIDTH(DW), .C_BUF_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .data_length_i(data_length_i),
      .sent_trig_i(sent_trig_i),
      .buf_rd_en_o(buf_rd_en_o),
      .buf_rd_addr_o(buf_rd_addr_o),
      .buf_rd_data_i(buf_rd_data_i),
      .tx_data_o(tx_data_o),
      .tx_start_o(tx_start_o),
      .tx_done_i(tx_done_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .byte_cnt_o(byte_cnt_o)
`ifdef UART_SEQ_ABORT_EN
      ,
      .abort_i(abort_i)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared state between the main sequence and the response models.
   logic [31:0] mem [256];
   int unsigned tx_delay_lo = 1, tx_delay_hi = 1;
   bit          inject_en = 1'b0;

   // Observation records (written only by the response process).
   logic [7:0] obs_data[$];
   int         obs_start_cyc[$];
   int         obs_txd_cyc[$];
   int         obs_addr[$];
   int         done_cyc_q[$];
   logic       done_busy_q[$];
   int         n_done = 0;
   int         hold_err = 0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int i);
      logic [31:0] w;
      w = mem[(i / 4) % 256];
      return 8'(w >> (8 * (i % 4)));
   endfunction

   // Buffer RAM and UART TX response models, sampled on the falling edge.
   initial begin
      bit          rd_pend;
      logic [7:0]  rd_pend_addr;
      int unsigned cnt_down;
      rd_pend = 1'b0; rd_pend_addr = '0; cnt_down = 0;
      uart_done = 1'b0; inj_done = 1'b0; buf_rd_data_i = '0;
      forever begin
         @(negedge clk);
         uart_done = 1'b0;
         inj_done  = 1'b0;
         buf_rd_data_i = rd_pend ? mem[rd_pend_addr] : $urandom();
         rd_pend      = (buf_rd_en_o === 1'b1);
         rd_pend_addr = buf_rd_addr_o;
         if (buf_rd_en_o === 1'b1) obs_addr.push_back(int'(buf_rd_addr_o));
         if (!rst_n) cnt_down = 0;
         else if (tx_start_o === 1'b1) begin
            obs_data.push_back(tx_data_o);
            obs_start_cyc.push_back(cyc);
            cnt_down = $urandom_range(tx_delay_hi, tx_delay_lo);
         end else if (cnt_down > 0) begin
            cnt_down--;
            if (cnt_down == 0) begin
               uart_done = 1'b1;
               obs_txd_cyc.push_back(cyc);
               if (tx_data_o !== obs_data[$]) hold_err++;
            end
         end
         // Spurious completions while the DUT cannot be waiting on one.
         if (inject_en && (tx_start_o === 1'b1 || buf_rd_en_o === 1'b1))
            inj_done = 1'b1;
         if (done_o === 1'b1) begin
            n_done++;
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy_o);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
   endtask

   // One complete transfer checked against the buffer-derived expectation.
   task automatic run_transfer(input int len, input int unsigned dlo,
                               input int unsigned dhi, input bit inject,
                               input bit hold);
      int b_data, b_addr, b_done, b_txd, b_hold, t_trig, k, n_st, n_rd, budget;
      tx_delay_lo = dlo; tx_delay_hi = dhi; inject_en = inject;
      b_data = obs_data.size(); b_addr = obs_addr.size();
      b_done = n_done; b_txd = obs_txd_cyc.size(); b_hold = hold_err;
      sent_trig_i = 1'b0;
      step();
      data_length_i = LW'(len);
      sent_trig_i   = 1'b1;
      t_trig        = cyc;
      step();
      check_eq("accept_rd_en", buf_rd_en_o, len != 0);
      check_eq("accept_busy", busy_o, len != 0);
      check_eq("accept_done", done_o, len == 0);
      data_length_i = LW'($urandom());
      if (!hold) sent_trig_i = 1'b0;
      if (inject) begin
         repeat (3) step();
         sent_trig_i = 1'b1;
         step();
         sent_trig_i = 1'b0;
      end
      budget = len * int'(dhi + 4) + 20;
      k = 0;
      while (n_done == b_done && k < budget) begin
         step();
         k++;
      end
      if (n_done == b_done) check_eq("done_timeout", 32'd0, 32'd1);
      step();
      step();
      inject_en = 1'b0;
      check_eq("done_pulses", n_done - b_done, 1);
      check_eq("byte_cnt", byte_cnt_o, len);
      check_eq("busy_after", busy_o, 1'b0);
      if (n_done > b_done) begin
         check_eq("busy_at_done", done_busy_q[b_done], 1'b0);
         if (len == 0)
            check_eq("done_lat_zero", done_cyc_q[b_done] - t_trig, 1);
         else if (obs_txd_cyc.size() >= b_txd + len)
            check_eq("done_lat", done_cyc_q[b_done] - obs_txd_cyc[b_txd + len - 1], 1);
      end
      n_st = obs_data.size() - b_data;
      check_eq("start_count", n_st, len);
      for (int i = 0; i < n_st && i < len; i++)
         check_eq("tx_byte", obs_data[b_data + i], exp_byte(i));
      if (n_st > 0) check_eq("first_start_lat", obs_start_cyc[b_data] - t_trig, 3);
      for (int i = 1; i < n_st && i < len; i++)
         if (obs_txd_cyc.size() > b_txd + i - 1)
            check_eq("start_gap", obs_start_cyc[b_data + i] - obs_txd_cyc[b_txd + i - 1],
                     (i % 4 == 0) ? 3 : 1);
      n_rd = obs_addr.size() - b_addr;
      check_eq("read_count", n_rd, (len + 3) / 4);
      for (int i = 0; i < n_rd && i < (len + 3) / 4; i++)
         check_eq("read_addr", obs_addr[b_addr + i], i % 256);
      check_eq("tx_data_hold", hold_err - b_hold, 0);
   endtask

   initial begin
      int b_data, b_addr, b_done, k, len;
      rst_n = 1'b0; sent_trig_i = 1'b0; data_length_i = '0; main_done = 1'b0;
`ifdef UART_SEQ_ABORT_EN
      abort_i = 1'b0;
`endif
      fill_mem();
      repeat (3) step();
      check_eq("rst_outputs",
               {22'd0, buf_rd_en_o, tx_start_o, busy_o, done_o, byte_cnt_o == '0,
                buf_rd_addr_o == '0, tx_data_o == '0, 3'd0},
               {22'd0, 4'b0000, 3'b111, 3'd0});
      rst_n = 1'b1;
      step();

      // Directed: five bytes across two words with slow UART completions.
      mem[0] = 32'h4433_2211; mem[1] = 32'h0000_0055;
      run_transfer(5, 20, 20, 1'b0, 1'b0);
      check_eq("dir_last_byte", obs_data[$], 8'h55);

      // Zero length.
      run_transfer(0, 1, 1, 1'b0, 1'b0);

      // Extra trigger edge and spurious completions mid-transfer.
      fill_mem();
      run_transfer(3, 5, 9, 1'b1, 1'b0);

      // Random lengths and UART latencies.
      for (int t = 0; t < 8; t++) begin
         fill_mem();
         len = int'($urandom_range(40, 1));
         run_transfer(len, 1, 5, 1'b0, 1'b0);
      end

      // Maximum length, trigger left high afterwards.
      fill_mem();
      mem[255] = 32'hA5C3_F00D;
      run_transfer(1023, 1, 2, 1'b0, 1'b1);
      check_eq("max_last_addr", obs_addr[$], 255);
      b_data = obs_data.size(); b_addr = obs_addr.size(); b_done = n_done;
      repeat (10) step();
      check_eq("held_trig_starts", obs_data.size() - b_data, 0);
      check_eq("held_trig_reads", obs_addr.size() - b_addr, 0);
      check_eq("held_trig_busy", busy_o, 1'b0);
      sent_trig_i = 1'b0;
      step();

      // Reset while the third of four bytes is in flight.
      fill_mem();
      tx_delay_lo = 6; tx_delay_hi = 6;
      b_data = obs_data.size();
      data_length_i = LW'(4);
      sent_trig_i = 1'b1;
      step();
      sent_trig_i = 1'b0;
      k = 0;
      while (obs_data.size() < b_data + 3 && k < 60) begin step(); k++; end
      check_eq("rst_mid_reached", obs_data.size() - b_data, 3);
      step();
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_busy", busy_o, 1'b0);
      check_eq("rst_mid_cnt", byte_cnt_o, 0);
      check_eq("rst_mid_data", tx_data_o, 0);
      check_eq("rst_mid_addr", buf_rd_addr_o, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      b_data = obs_data.size(); b_addr = obs_addr.size();
      main_done = 1'b1;
      step();
      main_done = 1'b0;
      repeat (3) step();
      check_eq("late_done_busy", busy_o, 1'b0);
      check_eq("late_done_cnt", byte_cnt_o, 0);
      check_eq("late_done_starts", obs_data.size() - b_data, 0);
      check_eq("late_done_reads", obs_addr.size() - b_addr, 0);
      run_transfer(4, 1, 4, 1'b0, 1'b0);

`ifdef UART_SEQ_ABORT_EN
      // Abort during the third byte of eight.
      fill_mem();
      tx_delay_lo = 6; tx_delay_hi = 6;
      b_data = obs_data.size(); b_done = n_done;
      sent_trig_i = 1'b0;
      step();
      data_length_i = LW'(8);
      sent_trig_i = 1'b1;
      step();
      sent_trig_i = 1'b0;
      k = 0;
      while (obs_data.size() < b_data + 3 && k < 60) begin step(); k++; end
      step();
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      k = 0;
      while (n_done == b_done && k < 60) begin step(); k++; end
      repeat (10) step();
      check_eq("abort_done", n_done - b_done, 1);
      check_eq("abort_starts", obs_data.size() - b_data, 3);
      check_eq("abort_cnt", byte_cnt_o, 3);
      for (int i = 0; i < 3; i++) check_eq("abort_byte", obs_data[b_data + i], exp_byte(i));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
